dvp_tx: RTL
===========

DVP_TX -- requirements
Module: dvp_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line (2 bytes each, RGB565).
REQ-002 SHALL have parameter H_BLANK, default 144, blanking byte-times per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameters VS_LINES=3, V_BACK=17, V_FRONT=10, meaning Vsyn-high, back-porch and front-porch line counts.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on posedge clk.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port capture  in  1  level request to stream frames.
REQ-008 SHALL have ports Pclk (out, 1, pixel clock), Href (out, 1, line valid) and Vsyn (out, 1, frame sync).
REQ-009 SHALL have port data  out  8  pixel byte, high byte of RGB565 first.
REQ-010 SHALL have ports frame_done (out, 1, one-clk pulse at frame end) and busy (out, 1, frame in progress).

Function
REQ-011 Pclk SHALL be a register that toggles every clk cycle (Pclk = clk/2).
REQ-012 Href, Vsyn, data and the counters SHALL update only on the clk edge where Pclk goes 1->0 (byte tick), so each value is stable across the following Pclk rising edge.
REQ-013 Timing: hcnt SHALL run 0..H_TOTAL-1 with H_TOTAL = 2*H_ACTIVE+H_BLANK; vcnt SHALL run 0..V_TOTAL-1 with V_TOTAL = VS_LINES+V_BACK+V_ACTIVE+V_FRONT; each SHALL advance per byte tick and wrap to 0.
REQ-014 FSM states SHALL be IDLE, VSYNC, VBACK, ACTIVE and VFRONT, with transitions taken at line wrap (hcnt = H_TOTAL-1).
REQ-015 IDLE->VSYNC SHALL occur on the first byte tick with capture=1, with hcnt=vcnt=0.
REQ-016 Vsyn SHALL be 1 only in VSYNC; Href SHALL be 1 only in ACTIVE with hcnt < 2*H_ACTIVE.
REQ-017 data SHALL be 0x00 whenever Href=0.
REQ-018 At the last byte of VFRONT, the FSM SHALL go to VSYNC if capture=1, else to IDLE; capture falling mid-frame SHALL NOT truncate the frame.
REQ-019 frame_done SHALL pulse for exactly one clk on the byte tick ending the last Href byte of the last active line.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Pixel index px = hcnt>>1; the active line index ly SHALL be 0..V_ACTIVE-1.

Reset
REQ-022 On rst=1 at a clk edge, the next cycle SHALL show Pclk=0, Href=0, Vsyn=0, data=0, frame_done=0 and busy=0, with the FSM in IDLE and counters at 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no frame_done; rst SHALL take priority over capture.

Configuration
REQ-024 With DVP_TX_BARS_EN defined, active pixels SHALL be 8 vertical bars of width H_ACTIVE/8, coloured white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
REQ-025 Without DVP_TX_BARS_EN, each active byte SHALL be (hcnt[7:0] + ly[7:0]) mod 256, and no bar logic SHALL be synthesized.

Structure
REQ-026 Package dvp_pkg SHALL hold the FSM state enum, the RGB565 bar colour constants, and the default timing constants.
REQ-027 Sub-module dvp_tx_timing SHALL own hcnt/vcnt and the wrap strobes; dvp_tx SHALL hold the FSM and the pixel generator.

Verification (H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VS_LINES=1, V_BACK=1, V_FRONT=1)
REQ-028 After reset, with capture=0 for 100 clk -> Pclk toggles, Href=Vsyn=busy=0, data=0.
REQ-029 Pulse capture=1 for one byte tick -> Vsyn high for 20 byte ticks, then 4 lines of 16 Href bytes each, frame_done once, busy falls after the front porch, return to IDLE.
REQ-030 With capture held at 1 -> frames run back-to-back with 140 byte ticks between frame_done pulses, and a Pclk-rising sampler counts 64 bytes per frame.
REQ-031 With bars enabled -> line 0 bytes are FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00; without bars -> line 1 bytes are 01..10 hex.
REQ-032 Assert rst during ACTIVE line 2 -> all outputs 0 the next cycle, no frame_done, and a new capture restarts at VSYNC.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP camera-style transmitter:
// FSM state encoding, default video timing and RGB565 colour-bar palette.
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } dvp_state_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_BLANK  = 144;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_VS_LINES = 3;
    localparam int DEF_V_BACK   = 17;
    localparam int DEF_V_FRONT  = 10;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Bars run left to right in classic SMPTE-like order.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// Pixel-clock divider plus horizontal/vertical byte counters for dvp_tx.
// Counters advance only on the byte tick (the clk edge where Pclk falls).
module dvp_tx_timing #(
    parameter int H_TOTAL = 1424,
    parameter int V_TOTAL = 510,
    parameter int HW      = $clog2(H_TOTAL + 1),
    parameter int VW      = $clog2(V_TOTAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          pclk,
    output logic          tick,
    output logic          line_end,
    output logic          frame_end,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt
);

    assign tick      = pclk;
    assign line_end  = tick && (hcnt == HW'(H_TOTAL - 1));
    assign frame_end = line_end && (vcnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            pclk <= ~pclk;
            if (tick) begin
                // While idle the counters sit at zero so a frame always starts at line 0, byte 0.
                if (!run) begin
                    hcnt <= '0;
                    vcnt <= '0;
                end else if (line_end) begin
                    hcnt <= '0;
                    vcnt <= frame_end ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dvp_tx.sv
// DVP (parallel camera) transmitter: frame sequencing FSM and RGB565 pixel generator.
// Define DVP_TX_BARS_EN to emit 8 colour bars instead of the (hcnt + line) ramp pattern.
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int VS_LINES = DEF_VS_LINES,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_FRONT  = DEF_V_FRONT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    output logic       Pclk,
    output logic       Href,
    output logic       Vsyn,
    output logic [7:0] data,
    output logic       frame_done,
    output logic       busy
);

    // state  | meaning
    // IDLE   | no frame; counters held at 0, waiting for capture
    // VSYNC  | Vsyn high for VS_LINES lines
    // VBACK  | vertical back porch
    // ACTIVE | V_ACTIVE lines, Href over the first 2*H_ACTIVE bytes of each
    // VFRONT | vertical front porch; restart or stop on the last byte

    localparam int H_TOTAL    = 2 * H_ACTIVE + H_BLANK;
    localparam int V_TOTAL    = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW         = $clog2(H_TOTAL + 1);
    localparam int VW         = $clog2(V_TOTAL + 1);
    localparam int ACT_FIRST  = VS_LINES + V_BACK;
    localparam int ACT_LAST   = ACT_FIRST + V_ACTIVE - 1;
    localparam int HREF_BYTES = 2 * H_ACTIVE;

    dvp_state_e    state;
    dvp_state_e    state_nxt;
    logic          tick;
    logic          line_end;
    logic          frame_end;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] ly;
    logic [7:0]    pix_byte;
    logic          fd_set;
    logic          run;

    assign run = (state != IDLE);

    dvp_tx_timing #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .HW      (HW),
        .VW      (VW)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .pclk      (Pclk),
        .tick      (tick),
        .line_end  (line_end),
        .frame_end (frame_end),
        .hcnt      (hcnt),
        .vcnt      (vcnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick && capture) state_nxt = VSYNC;
            VSYNC:   if (line_end && vcnt == VW'(VS_LINES - 1)) state_nxt = VBACK;
            VBACK:   if (line_end && vcnt == VW'(ACT_FIRST - 1)) state_nxt = ACTIVE;
            ACTIVE:  if (line_end && vcnt == VW'(ACT_LAST)) state_nxt = VFRONT;
            // Capture is only consulted here, so dropping it mid-frame never truncates.
            VFRONT:  if (frame_end) state_nxt = capture ? VSYNC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ly = vcnt - VW'(ACT_FIRST);

`ifdef DVP_TX_BARS_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [HW-1:0] px;
    logic [HW-1:0] bar_idx;
    logic [15:0]   bar_rgb;

    always_comb begin
        px       = hcnt >> 1;
        bar_idx  = px / HW'(BAR_W);
        bar_rgb  = bar_colour((bar_idx > HW'(7)) ? 3'd7 : bar_idx[2:0]);
        pix_byte = hcnt[0] ? bar_rgb[7:0] : bar_rgb[15:8];
    end
`else
    always_comb begin
        pix_byte = 8'(hcnt) + 8'(ly);
    end
`endif

    always_comb begin
        busy   = (state != IDLE);
        Vsyn   = (state == VSYNC);
        Href   = (state == ACTIVE) && (hcnt < HW'(HREF_BYTES));
        data   = Href ? pix_byte : 8'h00;
        fd_set = tick && Href && (hcnt == HW'(HREF_BYTES - 1))
                 && (ly == VW'(V_ACTIVE - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= fd_set;
        end
    end

endmodule
